// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: FSM state encoding, access-size
// constants and the alignment rule used when an access is accepted.
// Ports: none (package).
// ----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Size 3 is not a legal encoding; it behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SIZE_W : size;
    endfunction

    // Halves must be 2-byte aligned, words 4-byte aligned; bytes never fault.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return addr_lo[0];
            default: return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// ----------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data formatter. Moves the addressed byte/half of the
// returned memory word down to bit 0 and sign- or zero-extends it.
// Ports:
//   rdata       in  32  raw word returned by the data SRAM
//   addr_lo     in  2   byte offset of the access within the word
//   size        in  2   SIZE_B / SIZE_H / SIZE_W (already normalised)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   data        out 32  formatted load result
// ----------------------------------------------------------------------------
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    // Only the low half of the shifted word can ever be selected for
    // byte/half loads, so the upper bits are dropped right here.
    logic [15:0] shifted_lo;

    assign shifted_lo = 16'(rdata >> {addr_lo, 3'b000});

    always_comb begin
        data = rdata;
        case (size)
            SIZE_B: data = is_unsigned ? {24'h0, shifted_lo[7:0]}
                                       : {{24{shifted_lo[7]}}, shifted_lo[7:0]};
            SIZE_H: data = is_unsigned ? {16'h0, shifted_lo}
                                       : {{16{shifted_lo[15]}}, shifted_lo};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// lsu
// Load/store unit between the EX stage and a data SRAM with an addr_ok/data_ok
// handshake. One access outstanding at a time; misaligned accesses are
// answered locally with an address-error response.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   req_valid/req_ready         request handshake from EX
//   req_wr, req_size,
//   req_unsigned, req_addr,
//   req_wdata                   access description (store data LSB-aligned)
//   resp_valid/resp_ready       response handshake toward WB
//   resp_rdata, resp_ade        load result / address-error flag
//   data_sram_req/wr/size/
//   addr/wstrb/wdata            registered SRAM request
//   data_sram_addr_ok,
//   data_sram_data_ok,
//   data_sram_rdata             SRAM handshake and read data
// ----------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_ade,

    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata
);

    lsu_state_t  state;
    lsu_state_t  state_nxt;

    logic        wr_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  addr_lo_q;

    logic [1:0]  eff_size;
    logic        accept;
    logic        misaligned;
    logic [3:0]  store_wstrb;
    logic [31:0] store_wdata;
    logic [31:0] load_data;

    assign eff_size   = norm_size(req_size);
    assign accept     = (state == S_IDLE) && req_valid;
    assign misaligned = is_misaligned(eff_size, req_addr[1:0]);
    // Gated with resetn so EX never sees a handshake while reset is held.
    assign req_ready  = resetn && (state == S_IDLE);
    assign resp_valid = (state == S_RESP);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_valid)         state_nxt = misaligned ? S_RESP : S_REQ;
            S_REQ:  if (data_sram_addr_ok) state_nxt = S_WAIT;
            S_WAIT: if (data_sram_data_ok) state_nxt = S_RESP;
            S_RESP: if (resp_ready)        state_nxt = S_IDLE;
            default:                       state_nxt = S_IDLE;
        endcase
    end

    // Store data is replicated across all byte lanes so the strobe alone
    // selects the destination bytes; loads present no data and no strobes.
    always_comb begin
        store_wstrb = 4'b0000;
        store_wdata = 32'h0;
        if (req_wr) begin
            case (eff_size)
                SIZE_B: begin
                    store_wstrb = 4'b0001 << req_addr[1:0];
                    store_wdata = {4{req_wdata[7:0]}};
                end
                SIZE_H: begin
                    store_wstrb = 4'b0011 << req_addr[1:0];
                    store_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    store_wstrb = 4'b1111;
                    store_wdata = req_wdata;
                end
            endcase
        end
    end

    lsu_load_align u_load_align (
        .rdata       (data_sram_rdata),
        .addr_lo     (addr_lo_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (load_data)
    );

    // The SRAM request is captured on acceptance and held untouched until
    // addr_ok, which keeps it stable under memory backpressure. The response
    // registers only change on entry to RESP, so they stay stable under WB
    // backpressure.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_q            <= 1'b0;
            uns_q           <= 1'b0;
            size_q          <= SIZE_B;
            addr_lo_q       <= 2'b00;
            data_sram_req   <= 1'b0;
            data_sram_wr    <= 1'b0;
            data_sram_size  <= 2'b00;
            data_sram_addr  <= 32'h0;
            data_sram_wstrb <= 4'b0000;
            data_sram_wdata <= 32'h0;
            resp_rdata      <= 32'h0;
            resp_ade        <= 1'b0;
        end else begin
            if (accept) begin
                wr_q      <= req_wr;
                uns_q     <= req_unsigned;
                size_q    <= eff_size;
                addr_lo_q <= req_addr[1:0];
                if (misaligned) begin
                    resp_ade   <= 1'b1;
                    resp_rdata <= 32'h0;
                end else begin
                    data_sram_req   <= 1'b1;
                    data_sram_wr    <= req_wr;
                    data_sram_size  <= eff_size;
                    data_sram_addr  <= req_addr;
                    data_sram_wstrb <= store_wstrb;
                    data_sram_wdata <= store_wdata;
                end
            end
            if ((state == S_REQ) && data_sram_addr_ok) begin
                data_sram_req <= 1'b0;
            end
            if ((state == S_WAIT) && data_sram_data_ok) begin
                resp_ade   <= 1'b0;
                resp_rdata <= wr_q ? 32'h0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// ----------------------------------------------------------------------------
// tb_lsu
// Self-checking bench for lsu: a directed vector table, hand-written reset and
// backpressure sequences, and randomized accesses checked against a
// byte-level reference model. The bench also plays the data SRAM.
// ----------------------------------------------------------------------------
module tb_lsu;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_ade;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    lsu dut (
        .clk               (clk),
        .resetn            (resetn),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_wr            (req_wr),
        .req_size          (req_size),
        .req_unsigned      (req_unsigned),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_rdata        (resp_rdata),
        .resp_ade          (resp_ade),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_ade;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
    } vec_t;

    // ---------------- reference model (byte arithmetic) ----------------
    function automatic int model_nbytes(input logic [1:0] size);
        if (size == 2'd0) return 1;
        if (size == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic model_mis(input logic [1:0] size, input logic [31:0] addr);
        return (int'(addr % 4) % model_nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic wr, input logic [1:0] size,
                                               input logic [31:0] addr);
        int nb;
        int mask;
        if (!wr) return 4'h0;
        nb = model_nbytes(size);
        mask = ((1 << nb) - 1) << int'(addr % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic wr, input logic [1:0] size,
                                                input logic [31:0] wdata);
        logic [31:0] r;
        int nb;
        r = 32'h0;
        if (!wr) return r;
        nb = model_nbytes(size);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic wr, input logic [1:0] size,
                                               input logic uns, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        longint v;
        longint lim;
        int nb;
        if (wr) return 32'h0;
        nb = model_nbytes(size);
        if (nb == 4) return rdata;
        lim = longint'(1) << (8 * nb);
        v = (longint'(rdata) / (longint'(1) << (8 * int'(addr % 4)))) % lim;
        if (!uns && v >= lim / 2) v = v - lim;
        return v[31:0];
    endfunction

    // ---------------- checking ----------------
    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One complete access. Called and returning just after a falling edge.
    // da: cycles addr_ok is held low, dd: cycles before data_ok,
    // dr: cycles resp_ready is held low.
    task automatic apply_stimulus(input string tag, input logic wr, input logic [1:0] size,
                                  input logic uns, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  input logic exp_ade, input logic [31:0] exp_rdata,
                                  input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                                  input int da, input int dd, input int dr);
        logic [1:0] esz;
        esz = (size == 2'd3) ? 2'd2 : size;
        @(negedge clk);
        check_output({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_wr = wr; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_wr = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        if (!exp_ade) begin
            for (int i = 0; i <= da; i++) begin
                check_output({tag, " sram_req"},   32'(data_sram_req),   32'd1);
                check_output({tag, " sram_addr"},  data_sram_addr,       addr);
                check_output({tag, " sram_wr"},    32'(data_sram_wr),    32'(wr));
                check_output({tag, " sram_size"},  32'(data_sram_size),  32'(esz));
                check_output({tag, " sram_wstrb"}, 32'(data_sram_wstrb), 32'(exp_wstrb));
                check_output({tag, " sram_wdata"}, data_sram_wdata,      exp_wdata);
                check_output({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
                data_sram_addr_ok = (i == da);
                data_sram_data_ok = (i != da) ? 1'($urandom) : 1'b0;
                @(negedge clk);
            end
            data_sram_addr_ok = 1'b0;
            data_sram_data_ok = 1'b0;
            for (int i = 0; i <= dd; i++) begin
                check_output({tag, " sram_req wait"}, 32'(data_sram_req), 32'd0);
                check_output({tag, " resp_valid wait"}, 32'(resp_valid), 32'd0);
                data_sram_data_ok = (i == dd);
                data_sram_rdata = (i == dd) ? rdata : $urandom;
                @(negedge clk);
            end
            data_sram_data_ok = 1'b0;
            data_sram_rdata = $urandom;
        end
        for (int i = 0; i <= dr; i++) begin
            check_output({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
            check_output({tag, " resp_ade"},   32'(resp_ade),   32'(exp_ade));
            check_output({tag, " resp_rdata"}, resp_rdata,      exp_rdata);
            check_output({tag, " sram_req resp"}, 32'(data_sram_req), 32'd0);
            check_output({tag, " req_ready resp"}, 32'(req_ready), 32'd0);
            resp_ready = (i == dr);
            req_valid = 1'b1;
            data_sram_data_ok = 1'($urandom);
            @(negedge clk);
        end
        resp_ready = 1'b0;
        req_valid = 1'b0;
        data_sram_data_ok = 1'b0;
        check_output({tag, " resp_valid done"}, 32'(resp_valid), 32'd0);
        check_output({tag, " req_ready done"},  32'(req_ready),  32'd1);
    endtask

    vec_t        vecs[12];
    logic        r_wr;
    logic        r_uns;
    logic        r_mis;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h1003, 32'h0,        32'h80112233, 1'b0, 32'hFFFFFF80, 4'h0, 32'h0};
        vecs[1]  = '{1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000ABCD, 32'h55555555, 1'b0, 32'h0,        4'hC, 32'hABCDABCD};
        vecs[2]  = '{1'b0, 2'd2, 1'b0, 32'h3001, 32'h0,        32'h12345678, 1'b1, 32'h0,        4'h0, 32'h0};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h1003, 32'h0,        32'h80112233, 1'b0, 32'h00000080, 4'h0, 32'h0};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h0010, 32'h0,        32'h1234F00D, 1'b0, 32'hFFFFF00D, 4'h0, 32'h0};
        vecs[5]  = '{1'b1, 2'd0, 1'b0, 32'h0021, 32'hDEADBE5A, 32'h0,        1'b0, 32'h0,        4'h2, 32'h5A5A5A5A};
        vecs[6]  = '{1'b1, 2'd2, 1'b0, 32'h0024, 32'hCAFEF00D, 32'h0,        1'b0, 32'h0,        4'hF, 32'hCAFEF00D};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h0025, 32'h00001234, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
        vecs[8]  = '{1'b0, 2'd3, 1'b0, 32'h0048, 32'h0,        32'h87654321, 1'b0, 32'h87654321, 4'h0, 32'h0};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h004A, 32'h0,        32'h87654321, 1'b1, 32'h0,        4'h0, 32'h0};
        vecs[10] = '{1'b0, 2'd1, 1'b1, 32'h4002, 32'h0,        32'h9ABC0000, 1'b0, 32'h00009ABC, 4'h0, 32'h0};
        vecs[11] = '{1'b1, 2'd0, 1'b0, 32'h0033, 32'h000000FF, 32'h0,        1'b0, 32'h0,        4'h8, 32'hFFFFFFFF};

        resetn = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check_output("rst req_ready",  32'(req_ready),       32'd0);
        check_output("rst resp_valid", 32'(resp_valid),      32'd0);
        check_output("rst resp_rdata", resp_rdata,           32'h0);
        check_output("rst resp_ade",   32'(resp_ade),        32'd0);
        check_output("rst sram_req",   32'(data_sram_req),   32'd0);
        check_output("rst sram_wr",    32'(data_sram_wr),    32'd0);
        check_output("rst sram_size",  32'(data_sram_size),  32'd0);
        check_output("rst sram_addr",  data_sram_addr,       32'h0);
        check_output("rst sram_wstrb", 32'(data_sram_wstrb), 32'd0);
        check_output("rst sram_wdata", data_sram_wdata,      32'h0);
        resetn = 1'b1;

        // Directed table; vector 0 runs with a zero-wait memory
        for (int i = 0; i < 12; i++) begin
            apply_stimulus($sformatf("vec%0d", i), vecs[i].wr, vecs[i].size, vecs[i].uns,
                           vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].exp_ade,
                           vecs[i].exp_rdata, vecs[i].exp_wstrb, vecs[i].exp_wdata,
                           i % 3, (2 * i) % 3, (i + 2 * (i / 3)) % 3);
        end

        // Backpressure on both sides
        apply_stimulus("bp store", 1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000ABCD, 32'h0,
                       1'b0, 32'h0, 4'hC, 32'hABCDABCD, 3, 1, 2);
        apply_stimulus("bp load", 1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80112233,
                       1'b0, 32'hFFFFFF80, 4'h0, 32'h0, 3, 0, 2);

        // Reset while WAITing, then a late data_ok
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd2; req_addr = 32'h80; req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        data_sram_addr_ok = 1'b0;
        check_output("wait sram_addr", data_sram_addr, 32'h80);
        resetn = 1'b0;
        check_output("in-reset req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_output("mid rst resp_valid", 32'(resp_valid),      32'd0);
        check_output("mid rst sram_addr",  data_sram_addr,       32'h0);
        check_output("mid rst sram_wstrb", 32'(data_sram_wstrb), 32'd0);
        check_output("mid rst sram_wdata", data_sram_wdata,      32'h0);
        check_output("mid rst sram_wr",    32'(data_sram_wr),    32'd0);
        check_output("mid rst sram_size",  32'(data_sram_size),  32'd0);
        resetn = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h11111111;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        check_output("late data_ok resp_valid", 32'(resp_valid), 32'd0);
        check_output("late data_ok req_ready",  32'(req_ready),  32'd1);
        apply_stimulus("post rst", 1'b0, 2'd1, 1'b1, 32'h4002, 32'h0, 32'h9ABC0000,
                       1'b0, 32'h00009ABC, 4'h0, 32'h0, 0, 0, 0);

        // Randomized accesses against the model
        for (int t = 0; t < 40; t++) begin
            r_wr    = 1'($urandom);
            r_uns   = 1'($urandom);
            r_size  = 2'($urandom_range(0, 3));
            r_addr  = $urandom;
            if ($urandom_range(0, 3) != 0)
                r_addr = r_addr & ~32'(model_nbytes(r_size) - 1);
            r_wdata = $urandom;
            r_rdata = $urandom;
            r_mis   = model_mis(r_size, r_addr);
            apply_stimulus($sformatf("rand%0d", t), r_wr, r_size, r_uns, r_addr, r_wdata, r_rdata,
                           r_mis, r_mis ? 32'h0 : model_load(r_wr, r_size, r_uns, r_addr, r_rdata),
                           model_wstrb(r_wr, r_size, r_addr), model_wdata(r_wr, r_size, r_wdata),
                           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have ports clk input 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn input 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have req_valid input 1: the EX stage presents a memory access.
REQ-004 SHALL have req_ready output 1: the access is accepted this cycle.
REQ-005 SHALL have req_wr input 1: 1 = store, 0 = load.
REQ-006 SHALL have req_size input 2: 0 = byte, 1 = half, 2 = word; 3 is illegal and is treated as word.
REQ-007 SHALL have req_unsigned input 1: zero-extend load data.
REQ-008 SHALL have req_addr input 32: byte address, which is the ALU memory-address output.
REQ-009 SHALL have req_wdata input 32: store data, LSB-aligned.
REQ-010 SHALL have resp_valid output 1, resp_ready input 1, resp_rdata output 32 and resp_ade output 1 (address error) toward WB.
REQ-011 SHALL have data_sram_req output 1, data_sram_wr output 1, data_sram_size output 2, data_sram_addr output 32, data_sram_wstrb output 4 and data_sram_wdata output 32.
REQ-012 SHALL have data_sram_addr_ok input 1, data_sram_data_ok input 1 and data_sram_rdata input 32.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT and RESP, with one outstanding access maximum.
REQ-014 SHALL drive req_ready=1 only in IDLE; acceptance = IDLE & req_valid.
- On acceptance, SHALL latch wr, size, unsigned, addr[1:0] and the formatted request.
REQ-015 SHALL detect misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
- Misaligned access: SHALL go IDLE->RESP with resp_ade=1 and resp_rdata=0, and issue no SRAM request.
REQ-016 Aligned access: SHALL go IDLE->REQ, with data_sram_req=1 registered, first visible the cycle after acceptance.
REQ-017 SHALL hold all data_sram_* request outputs stable in REQ until data_sram_addr_ok=1, then go to WAIT; data_sram_req SHALL be 0 outside REQ.
REQ-018 In WAIT, data_sram_data_ok=1 SHALL go to RESP, capturing load data that cycle.
- data_sram_data_ok SHALL be ignored in all states except WAIT.
- The memory never returns data_ok in the same cycle as addr_ok.
REQ-019 In RESP, resp_valid SHALL be 1, and resp_rdata/resp_ade SHALL be held stable until resp_ready=1; then go to IDLE.
- A new request SHALL NOT be accepted in the same cycle as the response handshake.
REQ-020 Store formatting:
- wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
- wstrb: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111.
- data_sram_size = req_size.
REQ-021 Loads SHALL drive wstrb=0 and wdata=0.
REQ-022 Load formatting:
- shift rdata right by 8*addr[1:0], then take a byte or half.
- sign-extend by default; zero-extend when unsigned=1.
- word passes through unchanged.
REQ-023 Stores SHALL respond with resp_rdata=0 and resp_ade=0 after data_ok.
REQ-024 Minimum aligned latency: accept N, req N+1, addr_ok N+1, data_ok N+2, resp_valid N+3.

Reset
REQ-025 resetn=0 SHALL force IDLE and set these outputs to 0: resp_valid, resp_rdata, resp_ade, data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb and data_sram_wdata.
- req_ready SHALL read 0 during reset.
REQ-026 Reset during REQ, WAIT or RESP SHALL abandon the access silently.
- A late data_ok after reset SHALL be ignored, since the FSM is in IDLE.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding and the size constants SIZE_B=0, SIZE_H=1, SIZE_W=2.
REQ-028 Load extraction/extension SHALL be a combinational sub-module lsu_load_align (inputs rdata, addr_lo, size, unsigned; output 32-bit data).

Verification
REQ-029 Load byte, signed: addr=0x1003, size 0, rdata=0x80112233 -> resp_rdata=0xFFFFFF80, ade=0; resp_valid at N+3 with zero-wait memory.
REQ-030 Store half: addr=0x2002, wdata=0x0000ABCD -> wstrb=4'b1100, data_sram_wdata=0xABCDABCD, addr=0x2002; store response has rdata=0.
REQ-031 Misaligned word load: addr=0x3001 -> no data_sram_req ever, resp_valid next cycle, ade=1, rdata=0.
REQ-032 Backpressure: addr_ok held 0 for 3 cycles, then resp_ready held 0 for 2 cycles -> request outputs stable throughout, response held stable, req_ready stays 0 until IDLE.
REQ-033 Reset in WAIT, then data_ok pulse -> FSM in IDLE, no resp_valid; next load half unsigned at addr 0x4002 with rdata=0x9ABC0000 -> resp_rdata=0x00009ABC.
